// File: rtl/bit_population_pkg.sv
// Shared definitions for the set-bit position serializer.
//   state_t       : two-state control FSM encoding (IDLE / BUSY)
//   DEFAULT_WIDTH : default input word width in bits
package bit_population_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 128;

endpackage

// File: rtl/lsb_index_finder.sv
// Combinational lowest-set-bit locator.
// Ports:
//   data_i  [WIDTH-1:0]         word to search
//   idx_o   [$clog2(WIDTH)-1:0] index of the lowest set bit (0 when none)
//   any_o                       1 when data_i has at least one set bit
module lsb_index_finder #(
    parameter int unsigned WIDTH = 128
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     any_o
);

    localparam int unsigned IW = $clog2(WIDTH);

    logic          found;
    logic [IW-1:0] idx;

    // First hit scanning upward wins; later hits are masked by 'found'.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data_i[i] && !found) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign idx_o = idx;
    assign any_o = found;

endmodule

// File: rtl/bit_position_serializer.sv
// Emits the bit positions of every set bit of an accepted word, LSB first,
// one beat per cycle under valid/ready flow control. A zero word yields a
// single beat flagged empty.
// Ports:
//   clk_i        clock (rising edge)
//   srst_i       synchronous active-high reset
//   data_i       input word
//   data_val_i   data_i valid; accepted when ready_o is also 1
//   ready_o      block is idle and can accept a word
//   idx_o        index of the current set bit
//   idx_val_o    beat valid
//   idx_ready_i  downstream accepts the beat
//   idx_last_o   final beat of the current word
//   empty_o      current word had no set bits
//   cnt_o        set bits emitted so far for this word, including this beat
module bit_position_serializer
    import bit_population_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     data_val_i,
    output logic                     ready_o,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     idx_val_o,
    input  logic                     idx_ready_i,
    output logic                     idx_last_o,
    output logic                     empty_o,
    output logic [$clog2(WIDTH):0]   cnt_o
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned CW = IW + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] mask, mask_next;
    logic [CW-1:0]    cnt, cnt_next;

    logic [IW-1:0]    lsb_idx;
    logic             lsb_any;
    logic [WIDTH-1:0] mask_rest;
    logic             at_last;

    lsb_index_finder #(
        .WIDTH (WIDTH)
    ) u_finder (
        .data_i (mask),
        .idx_o  (lsb_idx),
        .any_o  (lsb_any)
    );

    // Mask with its lowest set bit removed; zero means the current beat is
    // the final one (one bit left, or nothing at all).
    assign mask_rest = mask & (mask - ONE);
    assign at_last   = (mask_rest == '0);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE;
            mask  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            mask  <= mask_next;
            cnt   <= cnt_next;
        end
    end

    // Beat outputs are forced to zero in IDLE so the idle/reset view is
    // clean even though mask==0 would otherwise look like a last beat.
    always_comb begin
        state_next = state;
        mask_next  = mask;
        cnt_next   = cnt;
        ready_o    = 1'b0;
        idx_val_o  = 1'b0;
        idx_o      = '0;
        idx_last_o = 1'b0;
        empty_o    = 1'b0;
        cnt_o      = '0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (data_val_i) begin
                    mask_next  = data_i;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                idx_val_o  = 1'b1;
                idx_o      = lsb_idx;
                idx_last_o = at_last;
                empty_o    = !lsb_any;
                cnt_o      = cnt + CW'(lsb_any);
                if (idx_ready_i) begin
                    mask_next = mask_rest;
                    cnt_next  = cnt + CW'(lsb_any);
                    if (at_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_position_serializer.sv
module tb_bit_position_serializer;

    localparam int W = 128;

    logic                 clk = 1'b0;
    logic                 srst;
    logic [W-1:0]         data;
    logic                 data_val;
    logic                 ready;
    logic [$clog2(W)-1:0] idx;
    logic                 idx_val;
    logic                 idx_ready;
    logic                 idx_last;
    logic                 empty;
    logic [$clog2(W):0]   cnt;

    int checks = 0;
    int errors = 0;

    bit_position_serializer #(
        .WIDTH (W)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .data_i      (data),
        .data_val_i  (data_val),
        .ready_o     (ready),
        .idx_o       (idx),
        .idx_val_o   (idx_val),
        .idx_ready_i (idx_ready),
        .idx_last_o  (idx_last),
        .empty_o     (empty),
        .cnt_o       (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: on acceptance, expand the word into its full list of
    // expected beats; each transfer pops one.
    typedef struct {
        int idx;
        int cnt;
        bit last;
        bit empty;
    } beat_t;

    beat_t q[$];

    function automatic void push_word(input logic [W-1:0] d);
        int    n;
        int    k;
        beat_t b;
        n = $countones(d);
        if (n == 0) begin
            b = '{idx: 0, cnt: 0, last: 1'b1, empty: 1'b1};
            q.push_back(b);
        end else begin
            k = 0;
            for (int i = 0; i < W; i++) begin
                if (d[i]) begin
                    k++;
                    b = '{idx: i, cnt: k, last: (k == n), empty: 1'b0};
                    q.push_back(b);
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            q.delete();
        end else if (q.size() != 0) begin
            if (idx_ready) void'(q.pop_front());
        end else if (data_val) begin
            push_word(data);
        end
    end

    always @(negedge clk) begin
        if (q.size() == 0) begin
            chk("m_ready", 32'(ready), 1);
            chk("m_val", 32'(idx_val), 0);
            chk("m_idx_idle", 32'(idx), 0);
            chk("m_last_idle", 32'(idx_last), 0);
            chk("m_empty_idle", 32'(empty), 0);
            chk("m_cnt_idle", 32'(cnt), 0);
        end else begin
            chk("m_ready", 32'(ready), 0);
            chk("m_val", 32'(idx_val), 1);
            chk("m_idx", 32'(idx), 32'(q[0].idx));
            chk("m_last", 32'(idx_last), 32'(q[0].last));
            chk("m_empty", 32'(empty), 32'(q[0].empty));
            chk("m_cnt", 32'(cnt), 32'(q[0].cnt));
        end
    end

    task automatic lit_beat(input string nm, input int e_idx, input int e_cnt, input bit e_last);
        @(negedge clk);
        chk({nm, "_val"}, 32'(idx_val), 1);
        chk({nm, "_idx"}, 32'(idx), 32'(e_idx));
        chk({nm, "_cnt"}, 32'(cnt), 32'(e_cnt));
        chk({nm, "_last"}, 32'(idx_last), 32'(e_last));
    endtask

    initial begin
        int    beats;
        int    last_idx;
        int    last_cnt;
        bit    done;

        srst      = 1'b1;
        data      = '0;
        data_val  = 1'b0;
        idx_ready = 1'b1;
        tick();
        tick();
        srst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_val", 32'(idx_val), 0);
        chk("rst_cnt", 32'(cnt), 0);
        tick();

        // 0x91 -> beats 0,4,7
        data     = W'(32'h91);
        data_val = 1'b1;
        @(negedge clk);
        chk("w91_pre_val", 32'(idx_val), 0);
        tick();
        data_val = 1'b0;
        lit_beat("w91_b0", 0, 1, 1'b0);
        tick();
        lit_beat("w91_b1", 4, 2, 1'b0);
        tick();
        lit_beat("w91_b2", 7, 3, 1'b1);
        tick();
        @(negedge clk);
        chk("w91_done_ready", 32'(ready), 1);
        tick();

        // Zero word -> single empty beat
        data     = '0;
        data_val = 1'b1;
        tick();
        data_val = 1'b0;
        lit_beat("zero", 0, 0, 1'b1);
        chk("zero_empty", 32'(empty), 1);
        tick();
        tick();

        // All ones -> 128 beats
        data     = '1;
        data_val = 1'b1;
        tick();
        data_val = 1'b0;
        beats = 0;
        done  = 1'b0;
        last_idx = -1;
        last_cnt = -1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (idx_val) begin
                beats++;
                if (idx_last) begin
                    last_idx = int'(idx);
                    last_cnt = int'(cnt);
                    done     = 1'b1;
                end
            end
            tick();
        end
        chk("ones_done", 32'(done), 1);
        chk("ones_beats", 32'(beats), 128);
        chk("ones_last_idx", 32'(last_idx), 127);
        chk("ones_last_cnt", 32'(last_cnt), 128);
        tick();

        // Bits 3 and 100 with 5 stalled cycles
        idx_ready = 1'b0;
        data      = '0;
        data[3]   = 1'b1;
        data[100] = 1'b1;
        data_val  = 1'b1;
        tick();
        data_val = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lit_beat("stall_hold", 3, 1, 1'b0);
            tick();
        end
        idx_ready = 1'b1;
        lit_beat("stall_b0", 3, 1, 1'b0);
        tick();
        lit_beat("stall_b1", 100, 2, 1'b1);
        tick();
        tick();

        // Reset after second beat of an all-ones word; data_val held high in reset
        data     = '1;
        data_val = 1'b1;
        tick();
        data_val = 1'b0;
        lit_beat("rmid_b0", 0, 1, 1'b0);
        tick();
        lit_beat("rmid_b1", 1, 2, 1'b0);
        tick();
        srst     = 1'b1;
        data     = W'(32'hF);
        data_val = 1'b1;
        tick();
        @(negedge clk);
        chk("rmid_val", 32'(idx_val), 0);
        chk("rmid_ready", 32'(ready), 1);
        tick();
        srst     = 1'b0;
        data_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rmid_no_beat", 32'(idx_val), 0);
            tick();
        end

        // data_val during BUSY ignored; word presented in the idle cycle taken
        data     = W'(32'h6);
        data_val = 1'b1;
        tick();
        data = W'(32'h80);
        lit_beat("busy_a0", 1, 1, 1'b0);
        tick();
        lit_beat("busy_a1", 2, 2, 1'b1);
        tick();
        @(negedge clk);
        chk("busy_idle_ready", 32'(ready), 1);
        tick();
        data_val = 1'b0;
        lit_beat("busy_b0", 7, 1, 1'b1);
        tick();

        // Drain with a bound
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (q.size() == 0 && ready) done = 1'b1;
            tick();
        end
        chk("drain", 32'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
